// File: rtl/mem_gate_pkg.sv
// Shared types and defaults for the memory request gate.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DENY
    } state_t;

    // Requester identifier: 0 is the privileged requester.
    typedef logic req_id_t;

    localparam int DEF_PROT_LO = 'hF0;
    localparam int DEF_TIMEOUT = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection; on a tie the requester not granted last wins.
// Latency: purely combinational, no state (last_grant is held by the parent).
// Backpressure: none; grant_valid is simply the OR of the two valids.
// Ports: valid0/valid1 request valids, last_grant previous winner,
//        grant selected requester id, grant_valid at least one requester valid.
module rr_arbiter2
    import mem_gate_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output req_id_t grant,
    output logic    grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/mem_req_gate.sv
// Round-robin front end for a single-port data memory with a write-protected upper region.
// Latency: allowed access strobes memory 1 cycle after accept, responds >= 3 cycles after accept;
//          denied access responds 1 cycle after accept. Backpressure: one access in flight, ready only in IDLE.
// Ports: reqN_* valid/ready request channels, rspN_* one-cycle response pulses,
//        mem_* registered strobe interface to the memory, mem_ready/mem_rdata back from it.
module mem_req_gate
    import mem_gate_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] PROT_LO    = ADDR_WIDTH'(DEF_PROT_LO),
    parameter int                    TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_we,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_we,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic                  mem_start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    req_id_t            last_grant;
    req_id_t            cur_id;
    logic               cur_we;
    logic [CNT_W-1:0]   cnt;

    req_id_t               gnt_id;
    logic                  gnt_vld;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_we;
    logic                  acc_deny;
    logic                  wait_done;

    rr_arbiter2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant       (gnt_id),
        .grant_valid (gnt_vld)
    );

    assign req0_ready = (state == IDLE) && gnt_vld && (gnt_id == 1'b0);
    assign req1_ready = (state == IDLE) && gnt_vld && (gnt_id == 1'b1);

    assign acc_addr  = gnt_id ? req1_addr  : req0_addr;
    assign acc_wdata = gnt_id ? req1_wdata : req0_wdata;
    assign acc_we    = gnt_id ? req1_we    : req0_we;
    // Only requester 1 can be denied; the protected range runs to the top address with no wrap.
    assign acc_deny  = gnt_id && acc_we && (acc_addr >= PROT_LO);

    // Completion either by the memory or by running out of WAIT cycles.
    assign wait_done = mem_ready || (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            cur_we     <= 1'b0;
            cnt        <= '0;
            mem_start  <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            // Strobes and response pulses last one cycle; address/data hold.
            mem_start  <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_rdata <= '0;

            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        cur_id     <= gnt_id;
                        cur_we     <= acc_we;
                        last_grant <= gnt_id;
                        if (acc_deny) begin
                            // Denied writes never touch the memory port.
                            state      <= DENY;
                            rsp1_valid <= 1'b1;
                            rsp1_err   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            mem_start <= 1'b1;
                            mem_we    <= acc_we;
                            mem_re    <= ~acc_we;
                            mem_addr  <= acc_addr;
                            mem_wdata <= acc_wdata;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        state <= RESP;
                        if (cur_id == 1'b0) begin
                            rsp0_valid <= 1'b1;
                            rsp0_err   <= ~mem_ready;
                            rsp0_rdata <= (mem_ready && !cur_we) ? mem_rdata : '0;
                        end else begin
                            rsp1_valid <= 1'b1;
                            rsp1_err   <= ~mem_ready;
                            rsp1_rdata <= (mem_ready && !cur_we) ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP, DENY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_gate.sv
// Self-checking bench for mem_req_gate with a behavioural memory and a transaction-level reference model.
// Latency: expected response timing is derived from memory latency and the timeout window.
// Backpressure: requests are held until ready; responses are never backpressured.
module tb_mem_req_gate;

    localparam int          DW  = 32;
    localparam int          AW  = 8;
    localparam int          T   = 8;
    localparam logic [7:0]  PLO = 8'hF0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_start, mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_req_gate #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROT_LO(PLO), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_we(req0_we),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_we(req1_we),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Behavioural memory: access happens at the strobe, ready rises mem_lat edges later and stays high.
    logic [DW-1:0] mem_arr [256];
    int            mem_lat = 0;
    int            lcnt = 0;
    assign mem_rdata = mem_arr[mem_addr];

    always @(posedge clk) begin
        if (mem_start) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            if (mem_lat == 0) begin
                mem_ready <= 1'b1;
            end else begin
                mem_ready <= 1'b0;
                lcnt      <= mem_lat;
            end
        end else if (!mem_ready && lcnt > 0) begin
            lcnt <= lcnt - 1;
            if (lcnt == 1) mem_ready <= 1'b1;
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [256];
    bit            model_last;
    int            nvec = 0;
    int            nfail = 0;

    function automatic void model(input bit id, input logic [7:0] addr, input bit we,
                                  input logic [DW-1:0] wd, input int lat,
                                  output bit e_err, output logic [DW-1:0] e_rd,
                                  output int e_dly, output int e_starts);
        bit allowed;
        allowed    = !(id && we && addr >= PLO);
        model_last = id;
        if (!allowed) begin
            e_err = 1; e_rd = '0; e_dly = 0; e_starts = 0;
        end else begin
            e_starts = 1;
            if (lat <= T - 1) begin
                e_err = 0; e_dly = 2 + lat; e_rd = we ? '0 : ref_mem[addr];
            end else begin
                e_err = 1; e_dly = 1 + T; e_rd = '0;
            end
            if (we) ref_mem[addr] = wd;
        end
    endfunction

    // Drives one request and reports what the DUT did; k counts cycles after the accept edge.
    task automatic drive_req(input bit id, input logic [7:0] addr, input bit we, input logic [DW-1:0] wd,
                             output int dly, output bit err, output logic [DW-1:0] rd,
                             output int starts, output int start_k, output bit s_we, output bit s_re,
                             output logic [7:0] s_addr, output logic [DW-1:0] s_wd, output int stray);
        int w;
        dly = -1; err = 0; rd = '0; starts = 0; start_k = -1; s_we = 0; s_re = 0;
        s_addr = '0; s_wd = '0; stray = 0; w = 0;
        if (id) begin
            req1_addr = addr; req1_we = we; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_addr = addr; req0_we = we; req0_wdata = wd; req0_valid = 1'b1;
        end
        #1;
        while (!(id ? req1_ready : req0_ready)) begin
            if (w >= 40) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                return;
            end
            w++;
            @(negedge clk); #1;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (mem_start) begin
                starts++; start_k = k; s_we = mem_we; s_re = mem_re; s_addr = mem_addr; s_wd = mem_wdata;
            end
            if (id ? rsp0_valid : rsp1_valid) stray++;
            if (id ? req0_ready : req1_ready) stray++;
            if (id ? rsp1_valid : rsp0_valid) begin
                dly = k;
                err = id ? rsp1_err : rsp0_err;
                rd  = id ? rsp1_rdata : rsp0_rdata;
                return;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [DW*3+AW+8-1:0] out_vec();
        return {mem_start, mem_we, mem_re, mem_addr, mem_wdata, rsp0_valid, rsp0_err, rsp0_rdata,
                rsp1_valid, rsp1_err, rsp1_rdata, req0_ready, req1_ready};
    endfunction

    int              dly, starts, start_k, stray, e_dly, e_starts;
    bit              err, s_we, s_re, e_err;
    logic [DW-1:0]   rd, s_wd, e_rd;
    logic [7:0]      s_addr;

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        repeat (3) @(negedge clk);
        model_last = 1'b1;
        nvec++;
        if (out_vec() !== '0) begin
            nfail++; $display("FAIL reset_outputs: got %h want 0", out_vec());
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        mem_lat = 0;
        model(0, 8'h10, 1, 32'hDEADBEEF, 0, e_err, e_rd, e_dly, e_starts);
        drive_req(0, 8'h10, 1, 32'hDEADBEEF, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (start_k !== 0 || starts !== 1) begin nfail++; $display("FAIL wr_start: got k=%0d n=%0d want k=0 n=1", start_k, starts); end
        nvec++; if (dly !== 2 || err !== 1'b0) begin nfail++; $display("FAIL wr_rsp: got dly=%0d err=%0b want dly=2 err=0", dly, err); end
        model(0, 8'h10, 0, 32'h0, 0, e_err, e_rd, e_dly, e_starts);
        drive_req(0, 8'h10, 0, 32'h0, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (rd !== 32'hDEADBEEF || err !== 1'b0 || dly !== 2) begin
            nfail++; $display("FAIL rd_back: got rd=%h err=%0b dly=%0d want rd=deadbeef err=0 dly=2", rd, err, dly);
        end
    endtask

    task automatic test_protect();
        logic [DW-1:0] prior;
        prior = ref_mem[8'hFF];
        model(1, 8'hFF, 1, 32'h12345678, 0, e_err, e_rd, e_dly, e_starts);
        drive_req(1, 8'hFF, 1, 32'h12345678, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (dly !== 0 || err !== 1'b1 || rd !== '0) begin
            nfail++; $display("FAIL deny_rsp: got dly=%0d err=%0b rd=%h want dly=0 err=1 rd=0", dly, err, rd);
        end
        // Look a few cycles past the deny response for any stray strobe.
        for (int i = 0; i < 3; i++) begin
            if (mem_start) starts++;
            @(negedge clk);
        end
        nvec++; if (starts !== 0) begin nfail++; $display("FAIL deny_no_start: got %0d strobes want 0", starts); end
        model(0, 8'hFF, 0, 32'h0, 0, e_err, e_rd, e_dly, e_starts);
        drive_req(0, 8'hFF, 0, 32'h0, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (rd !== prior || err !== 1'b0) begin
            nfail++; $display("FAIL deny_kept: got rd=%h err=%0b want rd=%h err=0", rd, err, prior);
        end
    endtask

    task automatic test_allowed();
        mem_lat = 1;
        model(1, 8'hFF, 0, 32'h0, 1, e_err, e_rd, e_dly, e_starts);
        drive_req(1, 8'hFF, 0, 32'h0, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (err !== 1'b0 || rd !== e_rd || dly !== 3) begin
            nfail++; $display("FAIL r1_read_prot: got err=%0b rd=%h dly=%0d want err=0 rd=%h dly=3", err, rd, dly, e_rd);
        end
        model(0, 8'hF5, 1, 32'hA5A5_0F0F, 1, e_err, e_rd, e_dly, e_starts);
        drive_req(0, 8'hF5, 1, 32'hA5A5_0F0F, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (err !== 1'b0 || starts !== 1 || s_we !== 1'b1 || s_addr !== 8'hF5 || s_wd !== 32'hA5A5_0F0F) begin
            nfail++; $display("FAIL r0_write_prot: got err=%0b n=%0d we=%0b addr=%h wd=%h want 0 1 1 f5 a5a50f0f",
                              err, starts, s_we, s_addr, s_wd);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_g;
        int grants, both;
        mem_lat = 0;
        exp_g = ~model_last; grants = 0; both = 0;
        req0_addr = 8'h20; req0_we = 0; req0_wdata = '0; req0_valid = 1'b1;
        req1_addr = 8'h21; req1_we = 0; req1_wdata = '0; req1_valid = 1'b1;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready || req1_ready) begin
                nvec++;
                if (req1_ready !== exp_g) begin
                    nfail++; $display("FAIL tie_order[%0d]: got %0b want %0b", grants, req1_ready, exp_g);
                end
                model_last = req1_ready;
                exp_g = ~exp_g;
                grants++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        nvec++; if (grants !== 4 || both !== 0) begin
            nfail++; $display("FAIL tie_grants: got grants=%0d both=%0d want 4 0", grants, both);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_timeout();
        mem_lat = 200;
        model(0, 8'h30, 0, 32'h0, 200, e_err, e_rd, e_dly, e_starts);
        drive_req(0, 8'h30, 0, 32'h0, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (dly !== 1 + T || err !== 1'b1 || rd !== '0 || starts !== 1) begin
            nfail++; $display("FAIL timeout: got dly=%0d err=%0b rd=%h n=%0d want dly=%0d err=1 rd=0 n=1", dly, err, rd, starts, 1 + T);
        end
        mem_lat = 0;
        model(0, 8'h31, 0, 32'h0, 0, e_err, e_rd, e_dly, e_starts);
        drive_req(0, 8'h31, 0, 32'h0, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
        nvec++; if (dly !== 2 || err !== 1'b0 || rd !== e_rd) begin
            nfail++; $display("FAIL after_timeout: got dly=%0d err=%0b rd=%h want dly=2 err=0 rd=%h", dly, err, rd, e_rd);
        end
    endtask

    task automatic test_reset_wait();
        int w, seen;
        mem_lat = 20;
        req0_addr = 8'h40; req0_we = 0; req0_wdata = '0; req0_valid = 1'b1;
        w = 0;
        #1;
        while (!req0_ready && w < 40) begin w++; @(negedge clk); #1; end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        model_last = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_last = 1'b1;
        nvec++; if (out_vec() !== '0) begin nfail++; $display("FAIL reset_in_wait: got %h want 0", out_vec()); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || mem_start) seen++;
        end
        nvec++; if (seen !== 0) begin nfail++; $display("FAIL reset_discard: got %0d events want 0", seen); end
        mem_lat = 0;
        req0_addr = 8'h41; req0_valid = 1'b1;
        req1_addr = 8'h42; req1_we = 0; req1_valid = 1'b1;
        #1;
        nvec++; if ({req0_ready, req1_ready} !== {1'b1, ~model_last}) begin
            nfail++; $display("FAIL reset_tie: got r0=%0b r1=%0b want r0=1 r1=0", req0_ready, req1_ready);
        end
        model_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        bit         t_id  [5] = '{1, 1, 1, 0, 0};
        bit         t_we  [5] = '{1, 1, 1, 0, 0};
        logic [7:0] t_adr [5] = '{8'hEF, 8'hF0, 8'hFF, 8'h55, 8'h56};
        int         t_lat [5] = '{0, 0, 0, T - 1, T};
        bit         id, we;
        logic [7:0] addr;
        logic [DW-1:0] wd;
        int lat, pick;
        for (int i = 0; i < 45; i++) begin
            if (i < 5) begin
                id = t_id[i]; we = t_we[i]; addr = t_adr[i]; lat = t_lat[i];
            end else begin
                id = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1));
                pick = $urandom_range(0, 4);
                addr = (pick == 0) ? 8'hF0 : (pick == 1) ? 8'hEF : (pick == 2) ? 8'hFF : 8'($urandom);
                lat = $urandom_range(0, 9);
            end
            wd = $urandom;
            mem_lat = lat;
            model(id, addr, we, wd, lat, e_err, e_rd, e_dly, e_starts);
            drive_req(id, addr, we, wd, dly, err, rd, starts, start_k, s_we, s_re, s_addr, s_wd, stray);
            nvec++; if (dly !== e_dly || err !== e_err || rd !== e_rd) begin
                nfail++; $display("FAIL rand_rsp[%0d]: got dly=%0d err=%0b rd=%h want dly=%0d err=%0b rd=%h",
                                  i, dly, err, rd, e_dly, e_err, e_rd);
            end
            nvec++; if (starts !== e_starts || stray !== 0) begin
                nfail++; $display("FAIL rand_start[%0d]: got n=%0d stray=%0d want n=%0d stray=0", i, starts, stray, e_starts);
            end
            if (e_starts == 1) begin
                nvec++;
                if (start_k !== 0 || s_we !== we || s_re !== !we || s_addr !== addr || (we && s_wd !== wd)) begin
                    nfail++; $display("FAIL rand_mem[%0d]: got k=%0d we=%0b re=%0b addr=%h wd=%h want k=0 we=%0b addr=%h wd=%h",
                                      i, start_k, s_we, s_re, s_addr, s_wd, we, addr, wd);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0101_0101 * i + 32'h1000_0000;
            ref_mem[i] = 32'h0101_0101 * i + 32'h1000_0000;
        end
        test_reset();
        test_back_to_back();
        test_write_read();
        test_protect();
        test_allowed();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", nvec);
        $fatal(1);
    end

endmodule
